reg_operand_sequencer: RTL

- Parametrised successor to the phase-clocked register selector.
- Holds an internal NREG-entry register bank with one write port. On a start request, it sequences two read phases that resolve operand A (sel_1) and operand B (sel_2) from registers, immediate, or zero.
- Sits between instruction decode and the ALU, and replaces the external clock_3/clock_5 phase strobes with an internal FSM and a valid/ack handshake.

---
 rtl/reg_operand_sequencer_if.sv | 33 +++
 rtl/reg_operand_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/reg_operand_sequencer_if.sv
// Handshake and bus bundle for reg_operand_sequencer: fetch request, register
// write port, result handshake and the legacy debug bus.
interface reg_operand_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4
) ();
    logic             start;
    logic [SEL_W-1:0] sel_1;
    logic [SEL_W-1:0] sel_2;
    logic [WIDTH-1:0] imm;
    logic             wr_en;
    logic [SEL_W-1:0] wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic             out_ack;
    logic             busy;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             sel_err;
    logic [WIDTH-1:0] bus_out;

    // Decoder / consumer side
    modport master (
        output start, sel_1, sel_2, imm, wr_en, wr_idx, wr_data, out_ack,
        input  busy, op_a, op_b, out_valid, sel_err, bus_out
    );

    // Sequencer side
    modport slave (
        input  start, sel_1, sel_2, imm, wr_en, wr_idx, wr_data, out_ack,
        output busy, op_a, op_b, out_valid, sel_err, bus_out
    );
endinterface

// File: rtl/reg_operand_sequencer.sv
// Two-phase operand sequencer: holds an NREG-entry register bank with one
// write port and, per accepted start, resolves operand A then operand B from
// a register (with write forwarding), the captured immediate, or zero.
module reg_operand_sequencer #(
    parameter int               WIDTH     = 32,
    parameter int               NREG      = 8,
    parameter int               SEL_W     = 4,
    parameter logic [SEL_W-1:0] IMM_CODE  = 4'hF,
    parameter int               SP_IDX    = 2,
    parameter logic [WIDTH-1:0] STACK_TOP = 32'h0000_0FFC
) (
    input logic                   clock,
    input logic                   reset,
    reg_operand_sequencer_if.slave bus
);
    localparam int               IDX_W  = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [SEL_W-1:0] NREG_C = SEL_W'(NREG);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PH1  = 2'd1,
        ST_PH2  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] bank_r [NREG];
    logic [SEL_W-1:0] sel_1_r;
    logic [SEL_W-1:0] sel_2_r;
    logic [WIDTH-1:0] imm_r;
    logic [WIDTH-1:0] op_a_r;
    logic [WIDTH-1:0] op_b_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             sel_err_r;
    logic             capture_s;
    logic             resolve_en_s;
    logic [SEL_W-1:0] cur_sel_s;
    logic [WIDTH-1:0] resolved_s;
    logic             bad_s;
    logic [WIDTH-1:0] bus_out_s;

    // Code addresses a bank register
    function automatic logic sel_is_bank(input logic [SEL_W-1:0] s);
        return (s < NREG_C);
    endfunction

    // Code is neither a bank register nor the immediate
    function automatic logic sel_is_bad(input logic [SEL_W-1:0] s);
        return (s >= NREG_C) && (s != IMM_CODE);
    endfunction

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; start is only honoured in IDLE or on an acked DONE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_next_s = ST_PH1;
                else           state_next_s = ST_IDLE;
            end
            ST_PH1:  state_next_s = ST_PH2;
            ST_PH2:  state_next_s = ST_DONE;
            ST_DONE: begin
                if (bus.out_ack && bus.start) state_next_s = ST_PH1;
                else if (bus.out_ack)         state_next_s = ST_IDLE;
                else                          state_next_s = ST_DONE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode: capture strobe and which selector is being resolved
    always_comb begin
        capture_s    = 1'b0;
        resolve_en_s = 1'b0;
        cur_sel_s    = sel_1_r;
        case (state_r)
            ST_IDLE: capture_s = bus.start;
            ST_PH1: begin
                resolve_en_s = 1'b1;
                cur_sel_s    = sel_1_r;
            end
            ST_PH2: begin
                resolve_en_s = 1'b1;
                cur_sel_s    = sel_2_r;
            end
            ST_DONE: capture_s = bus.out_ack & bus.start;
            default: capture_s = 1'b0;
        endcase
    end

    // Resolver: bank (same-cycle write forwarded), immediate, or zero+error
    always_comb begin
        resolved_s = {WIDTH{1'b0}};
        bad_s      = 1'b0;
        if (sel_is_bank(cur_sel_s)) begin
            if (bus.wr_en && (bus.wr_idx == cur_sel_s)) resolved_s = bus.wr_data;
            else                                         resolved_s = bank_r[cur_sel_s[IDX_W-1:0]];
        end else if (cur_sel_s == IMM_CODE) begin
            resolved_s = imm_r;
        end else begin
            resolved_s = {WIDTH{1'b0}};
            bad_s      = sel_is_bad(cur_sel_s);
        end
        if (resolve_en_s) bus_out_s = resolved_s;
        else              bus_out_s = {WIDTH{1'b0}};
    end

    // Register bank write port; out-of-range indices are dropped
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                bank_r[i] <= (i == SP_IDX) ? STACK_TOP : {WIDTH{1'b0}};
            end
        end else if (bus.wr_en && sel_is_bank(bus.wr_idx)) begin
            bank_r[bus.wr_idx[IDX_W-1:0]] <= bus.wr_data;
        end
    end

    // Capture selectors and immediate on an accepted start
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_1_r <= {SEL_W{1'b0}};
            sel_2_r <= {SEL_W{1'b0}};
            imm_r   <= {WIDTH{1'b0}};
        end else if (capture_s) begin
            sel_1_r <= bus.sel_1;
            sel_2_r <= bus.sel_2;
            imm_r   <= bus.imm;
        end
    end

    // Operand latches; held untouched through DONE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_a_r <= {WIDTH{1'b0}};
            op_b_r <= {WIDTH{1'b0}};
        end else if (state_r == ST_PH1) begin
            op_a_r <= resolved_s;
        end else if (state_r == ST_PH2) begin
            op_b_r <= resolved_s;
        end
    end

    // Sticky selector error for the current fetch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_err_r <= 1'b0;
        end else if (capture_s) begin
            sel_err_r <= 1'b0;
        end else if (resolve_en_s && bad_s) begin
            sel_err_r <= 1'b1;
        end
    end

    // Registered status flags tracking the next state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            out_valid_r <= (state_next_s == ST_DONE);
            busy_r      <= (state_next_s != ST_IDLE);
        end
    end

    assign bus.op_a      = op_a_r;
    assign bus.op_b      = op_b_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.sel_err   = sel_err_r;
    assign bus.bus_out   = bus_out_s;
endmodule
